// File: rtl/alu_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: alu_ctr opcode
//               constants and the controller state encoding.
//               Optional feature macro: SEQ_ALU_DIV_EN (adds the DIV state).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    // alu_ctr opcode encodings
    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_SLT   = 4'b0100;
    localparam logic [3:0] c_OP_ADD   = 4'b0101;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_MULTU = 4'b1000;
    localparam logic [3:0] c_OP_DIVU  = 4'b1001;

    // Controller states; DIV only exists when the divider is built
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd3
`ifdef SEQ_ALU_DIV_EN
        ,
        S_DIV  = 2'd2
`endif
    } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
//==============================================================================
// Module      : seq_alu_muldiv
// Description : Iterative multiply/divide engine, one bit per step.
//               MULTU: unsigned shift-add, {hi,lo} ends as the full product.
//               DIVU : unsigned restoring, lo ends as quotient, hi remainder.
//               Both modes share the hi/lo shift register, operand register
//               and bit counter. Divider path only present when
//               SEQ_ALU_DIV_EN is defined.
// Ports       : clk, rst_n      clock, synchronous active-low reset
//               i_load          capture operands and clear the counter
//               i_div_mode      (SEQ_ALU_DIV_EN only) 1 = divide, 0 = multiply
//               i_op_a, i_op_b  multiplier/dividend, multiplicand/divisor
//               i_step          perform one iteration this cycle
//               o_last          current step is the final one
//               o_res_lo/hi     register contents after the current step
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
`ifdef SEQ_ALU_DIV_EN
    input  logic             i_div_mode,
`endif
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_step,
    output logic             o_last,
    output logic [WIDTH-1:0] o_res_lo,
    output logic [WIDTH-1:0] o_res_hi
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_hi;
    logic [WIDTH-1:0] w_mul_lo;

`ifdef SEQ_ALU_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_hi;
    logic [WIDTH-1:0] w_div_lo;
`endif

    // Multiply step: conditionally add multiplicand into the upper half,
    // then shift the whole (WIDTH+1)-bit-carry product right by one.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_mul_hi = w_sum[WIDTH:1];
        w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    // Restoring divide step: shift the next dividend bit into the partial
    // remainder; subtract the divisor only if it fits. The difference is
    // always < divisor when it fits, so a WIDTH-bit subtract is exact.
    always_comb begin
        w_rem_sh = {r_hi, r_lo[WIDTH-1]};
        w_ge     = (w_rem_sh >= {1'b0, r_b});
        w_div_hi = w_ge ? (w_rem_sh[WIDTH-1:0] - r_b) : w_rem_sh[WIDTH-1:0];
        w_div_lo = {r_lo[WIDTH-2:0], w_ge};
    end

    assign o_res_lo = r_div ? w_div_lo : w_mul_lo;
    assign o_res_hi = r_div ? w_div_hi : w_mul_hi;
`else
    assign o_res_lo = w_mul_lo;
    assign o_res_hi = w_mul_hi;
`endif

    assign o_last = (r_cnt == c_LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_op_a;
            r_b   <= i_op_b;
            r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
            r_div <= i_div_mode;
`endif
        end else if (i_step) begin
            r_hi  <= o_res_hi;
            r_lo  <= o_res_lo;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : seq_alu_muldiv

`default_nettype wire

// File: rtl/seq_alu.sv
//==============================================================================
// Module      : seq_alu
// Description : Sequential ALU. AND/OR/SLT/ADD/SUB complete in one cycle;
//               MULTU (and DIVU when SEQ_ALU_DIV_EN is defined) iterate one
//               bit per cycle in seq_alu_muldiv. All outputs are registered
//               and held until the next accepted operation completes.
//               Optional feature macro: SEQ_ALU_DIV_EN (unsigned divider).
// Ports       : clk, rst_n            clock, synchronous active-low reset
//               start                 request; accepted only in IDLE/DONE
//               alu_ctr               4-bit operation select
//               alu_src1, alu_src2    operands (WIDTH bits)
//               busy                  multi-cycle op iterating
//               done                  one-cycle result-valid pulse
//               result_lo, result_hi  result words
//               zero_bit              result_lo == 0
//               ovf                   signed overflow of ADD/SUB
//               div_by_zero           DIVU with zero divisor
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_bit,
    output logic             ovf,
    output logic             div_by_zero
);

    state_t           r_state;

    logic             w_idle_or_done;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_eng_lo;
    logic [WIDTH-1:0] w_eng_hi;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sc_lo;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_ovf;
    logic             w_sc_dbz;

    //--------------------------------------------------------------------------
    // Operation classification and engine control
    //--------------------------------------------------------------------------
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_is_mul       = (alu_ctr == c_OP_MULTU);
`ifdef SEQ_ALU_DIV_EN
    // A zero divisor is resolved in one cycle and never enters the engine
    assign w_is_div = (alu_ctr == c_OP_DIVU) && (alu_src2 != '0);
    assign w_step   = (r_state == S_MUL) || (r_state == S_DIV);
`else
    assign w_is_div = 1'b0;
    assign w_step   = (r_state == S_MUL);
`endif
    assign w_load = rst_n && start && w_idle_or_done && (w_is_mul || w_is_div);

    seq_alu_muldiv #(
        .WIDTH      (WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
`ifdef SEQ_ALU_DIV_EN
        .i_div_mode (alu_ctr == c_OP_DIVU),
`endif
        .i_op_a     (alu_src1),
        .i_op_b     (alu_src2),
        .i_step     (w_step),
        .o_last     (w_last),
        .o_res_lo   (w_eng_lo),
        .o_res_hi   (w_eng_hi)
    );

    //--------------------------------------------------------------------------
    // Single-cycle datapath
    //--------------------------------------------------------------------------
    assign w_sum  = alu_src1 + alu_src2;
    assign w_diff = alu_src1 - alu_src2;

    always_comb begin
        w_sc_lo  = '0;
        w_sc_hi  = '0;
        w_sc_ovf = 1'b0;
        w_sc_dbz = 1'b0;
        unique case (alu_ctr)
            c_OP_AND: w_sc_lo = alu_src1 & alu_src2;
            c_OP_OR:  w_sc_lo = alu_src1 | alu_src2;
            c_OP_SLT: w_sc_lo = {{(WIDTH-1){1'b0}},
                                 ($signed(alu_src1) < $signed(alu_src2))};
            c_OP_ADD: begin
                w_sc_lo  = w_sum;
                // Like-signed operands producing an opposite-signed sum
                w_sc_ovf = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != alu_src1[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_sc_lo  = w_diff;
                // Unlike-signed operands where the sign of src1 is lost
                w_sc_ovf = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != alu_src1[WIDTH-1]);
            end
`ifdef SEQ_ALU_DIV_EN
            // Only the zero-divisor case of DIVU takes this path
            c_OP_DIVU: begin
                w_sc_lo  = '1;
                w_sc_hi  = alu_src1;
                w_sc_dbz = 1'b1;
            end
`endif
            default: begin
                w_sc_lo = '0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Controller and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            zero_bit    <= 1'b1;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                    if (start) begin
                        if (w_is_mul) begin
                            r_state <= S_MUL;
                            busy    <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
                        end else if (w_is_div) begin
                            r_state <= S_DIV;
                            busy    <= 1'b1;
`endif
                        end else begin
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            result_lo   <= w_sc_lo;
                            result_hi   <= w_sc_hi;
                            zero_bit    <= (w_sc_lo == '0);
                            ovf         <= w_sc_ovf;
                            div_by_zero <= w_sc_dbz;
                        end
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_MUL, S_DIV: begin
`else
                S_MUL: begin
`endif
                    // Start is ignored here; previous results stay visible
                    // until the final step lands.
                    if (w_last) begin
                        r_state     <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        result_lo   <= w_eng_lo;
                        result_hi   <= w_eng_hi;
                        zero_bit    <= (w_eng_lo == '0);
                        ovf         <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_alu

`default_nettype wire

// File: tb/tb_seq_alu.sv
//==============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking bench for seq_alu (WIDTH = 32).
//               Expectations follow SEQ_ALU_DIV_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int WIDTH = 32;

    localparam logic [3:0] c_AND   = 4'b0000;
    localparam logic [3:0] c_OR    = 4'b0001;
    localparam logic [3:0] c_SLT   = 4'b0100;
    localparam logic [3:0] c_ADD   = 4'b0101;
    localparam logic [3:0] c_SUB   = 4'b0110;
    localparam logic [3:0] c_MULTU = 4'b1000;
    localparam logic [3:0] c_DIVU  = 4'b1001;
    localparam logic [3:0] c_UNDEF = 4'b0011;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] alu_src1;
    logic [WIDTH-1:0] alu_src2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero_bit;
    logic             ovf;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_alu #(
        .WIDTH       (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctr     (alu_ctr),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero_bit    (zero_bit),
        .ovf         (ovf),
        .div_by_zero (div_by_zero)
    );

    // Issue one op for one cycle, then wait (bounded) for done.
    // lat = cycles from accept edge to the first sample showing done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int busy_cyc);
        @(negedge clk);
        alu_ctr  = op;
        alu_src1 = a;
        alu_src2 = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        alu_ctr  = c_ADD;
        alu_src1 = 32'd1;
        alu_src2 = 32'd1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, zero_bit, ovf, div_by_zero} !== 5'b00100 ||
            result_lo !== 32'h0 || result_hi !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: flags=%b lo=%h hi=%h, want flags=00100 lo=0 hi=0",
                     {busy, done, zero_bit, ovf, div_by_zero}, result_lo, result_hi);
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result_lo !== 32'h0) begin
            failures++;
            $display("FAIL start_during_reset: done=%b lo=%h, want done=0 lo=0",
                     done, result_lo);
        end
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(c_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h8000_0000 || result_hi !== 32'h0 ||
            ovf !== 1'b1 || zero_bit !== 1'b0 || bc !== 0) begin
            failures++;
            $display("FAIL add_ovf: lat=%0d lo=%h hi=%h ovf=%b z=%b busy=%0d, want 1 80000000 0 1 0 0",
                     lat, result_lo, result_hi, ovf, zero_bit, bc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result_lo !== 32'h8000_0000 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL add_hold: done=%b lo=%h ovf=%b, want 0 80000000 1",
                     done, result_lo, ovf);
        end
    endtask

    task automatic test_sub();
        int lat, bc;
        run_op(c_SUB, 32'd5, 32'd5, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h0 || zero_bit !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_zero: lat=%0d lo=%h z=%b ovf=%b, want 1 0 1 0",
                     lat, result_lo, zero_bit, ovf);
        end
        run_op(c_SUB, 32'h8000_0000, 32'h0000_0001, lat, bc);
        checks++;
        if (result_lo !== 32'h7FFF_FFFF || ovf !== 1'b1 || zero_bit !== 1'b0) begin
            failures++;
            $display("FAIL sub_ovf: lo=%h ovf=%b z=%b, want 7fffffff 1 0",
                     result_lo, ovf, zero_bit);
        end
    endtask

    task automatic test_slt();
        int lat, bc;
        run_op(c_SLT, 32'hFFFF_FFFF, 32'h0000_0001, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'd1 || result_hi !== 32'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL slt_neg_lt_pos: lat=%0d lo=%h hi=%h ovf=%b, want 1 1 0 0",
                     lat, result_lo, result_hi, ovf);
        end
        run_op(c_SLT, 32'h0000_0001, 32'hFFFF_FFFF, lat, bc);
        checks++;
        if (result_lo !== 32'd0 || zero_bit !== 1'b1) begin
            failures++;
            $display("FAIL slt_pos_vs_neg: lo=%h z=%b, want 0 1", result_lo, zero_bit);
        end
    endtask

    task automatic test_logic();
        int lat, bc;
        run_op(c_OR, 32'h0000_F0F0, 32'h0000_0F0F, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h0000_FFFF || result_hi !== 32'h0) begin
            failures++;
            $display("FAIL or: lat=%0d lo=%h hi=%h, want 1 0000ffff 0",
                     lat, result_lo, result_hi);
        end
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        checks++;
        if (lat !== 33 || bc !== 32 || result_hi !== 32'hFFFF_FFFE ||
            result_lo !== 32'h0000_0001 || ovf !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL multu_max: lat=%0d busy=%0d hi=%h lo=%h ovf=%b, want 33 32 fffffffe 00000001 0",
                     lat, bc, result_hi, result_lo, ovf);
        end
        run_op(c_MULTU, 32'h1234_5678, 32'h0000_0010, lat, bc);
        checks++;
        if (lat !== 33 || result_hi !== 32'h0000_0001 || result_lo !== 32'h2345_6780) begin
            failures++;
            $display("FAIL multu_shift: lat=%0d hi=%h lo=%h, want 33 00000001 23456780",
                     lat, result_hi, result_lo);
        end
    endtask

    task automatic test_divu();
        int lat, bc;
`ifdef SEQ_ALU_DIV_EN
        run_op(c_DIVU, 32'd100, 32'd7, lat, bc);
        checks++;
        if (lat !== 33 || bc !== 32 || result_lo !== 32'd14 || result_hi !== 32'd2 ||
            div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL divu_100_7: lat=%0d busy=%0d q=%0d r=%0d dbz=%b, want 33 32 14 2 0",
                     lat, bc, result_lo, result_hi, div_by_zero);
        end
        run_op(c_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, lat, bc);
        checks++;
        if (result_lo !== 32'h0FFF_FFFF || result_hi !== 32'h0000_000F) begin
            failures++;
            $display("FAIL divu_max: q=%h r=%h, want 0fffffff 0000000f", result_lo, result_hi);
        end
        run_op(c_DIVU, 32'h0000_1234, 32'h0, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'hFFFF_FFFF || result_hi !== 32'h0000_1234 ||
            div_by_zero !== 1'b1 || zero_bit !== 1'b0) begin
            failures++;
            $display("FAIL divu_by_zero: lat=%0d lo=%h hi=%h dbz=%b z=%b, want 1 ffffffff 00001234 1 0",
                     lat, result_lo, result_hi, div_by_zero, zero_bit);
        end
`else
        run_op(c_DIVU, 32'd100, 32'd7, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h0 || result_hi !== 32'h0 ||
            div_by_zero !== 1'b0 || zero_bit !== 1'b1) begin
            failures++;
            $display("FAIL divu_disabled: lat=%0d lo=%h hi=%h dbz=%b z=%b, want 1 0 0 0 1",
                     lat, result_lo, result_hi, div_by_zero, zero_bit);
        end
`endif
    endtask

    task automatic test_undefined();
        int lat, bc;
        run_op(c_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat, bc);
        run_op(c_UNDEF, 32'h0000_0005, 32'h0000_0005, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h0 || result_hi !== 32'h0 ||
            ovf !== 1'b0 || div_by_zero !== 1'b0 || zero_bit !== 1'b1) begin
            failures++;
            $display("FAIL undefined_op: lat=%0d lo=%h hi=%h ovf=%b dbz=%b z=%b, want 1 0 0 0 0 1",
                     lat, result_lo, result_hi, ovf, div_by_zero, zero_bit);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        alu_ctr  = c_MULTU;
        alu_src1 = 32'hFFFF_FFFF;
        alu_src2 = 32'hFFFF_FFFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                start    = 1'b1;
                alu_ctr  = c_ADD;
                alu_src1 = 32'd1;
                alu_src2 = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== 33 || result_hi !== 32'hFFFF_FFFE || result_lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL start_ignored_busy: lat=%0d hi=%h lo=%h, want 33 fffffffe 00000001",
                     lat, result_hi, result_lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(c_ADD, 32'd1, 32'd2, lat, bc);
        alu_ctr  = c_ADD;
        alu_src1 = 32'd3;
        alu_src2 = 32'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result_lo !== 32'd7) begin
            failures++;
            $display("FAIL back_to_back: done=%b lo=%0d, want 1 7", done, result_lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result_lo !== 32'd7) begin
            failures++;
            $display("FAIL done_to_idle: done=%b busy=%b lo=%0d, want 0 0 7",
                     done, busy, result_lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int  lat, bc;
        logic seen_done;
        @(negedge clk);
        alu_ctr  = c_MULTU;
        alu_src1 = 32'hFFFF_FFFF;
        alu_src2 = 32'hFFFF_FFFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, zero_bit, ovf, div_by_zero} !== 5'b00100 ||
            result_lo !== 32'h0 || result_hi !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_mul: flags=%b lo=%h hi=%h, want flags=00100 lo=0 hi=0",
                     {busy, done, zero_bit, ovf, div_by_zero}, result_lo, result_hi);
        end
        rst_n     = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: activity seen=%b, want 0", seen_done);
        end
        run_op(c_AND, 32'h0000_F0F0, 32'h0000_FF00, lat, bc);
        checks++;
        if (lat !== 1 || result_lo !== 32'h0000_F000 || result_hi !== 32'h0) begin
            failures++;
            $display("FAIL and_after_reset: lat=%0d lo=%h hi=%h, want 1 0000f000 0",
                     lat, result_lo, result_hi);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        alu_ctr  = 4'b0;
        alu_src1 = '0;
        alu_src2 = '0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_multu();
        test_divu();
        test_undefined();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case a wait never resolves
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule : tb_seq_alu

`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result word width in bits (SHALL be >= 4).
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request to begin the operation on alu_src1/alu_src2/alu_ctr.
REQ-005 Port: alu_ctr  input  4  op select: 0000 AND, 0001 OR, 0100 SLT, 0101 ADD, 0110 SUB, 1000 MULTU, 1001 DIVU; other codes undefined.
REQ-006 Port: alu_src1, alu_src2  input  WIDTH  operands, sampled only on an accepted start.
REQ-007 Port: busy  output  1  high while a multi-cycle op (MULTU/DIVU) is iterating.
REQ-008 Port: done  output  1  one-cycle pulse: result valid.
REQ-009 Port: result_lo, result_hi  output  WIDTH  result low word / high word (product high, or remainder).
REQ-010 Port: zero_bit  output  1  result_lo == 0.
REQ-011 Port: ovf  output  1  signed overflow (ADD/SUB).
REQ-012 Port: div_by_zero  output  1  DIVU with alu_src2 == 0.

Function
REQ-013 FSM states: IDLE, MUL, DIV, DONE; start SHALL be accepted only in IDLE or DONE.
REQ-014 Start ignored in MUL/DIV; no operand capture, no state change.
REQ-015 Single-cycle ops (AND/OR/SLT/ADD/SUB, undefined codes, DIVU by zero): accept at edge N -> DONE, done=1 in cycle N+1.
REQ-016 MULTU: unsigned shift-add, one bit per cycle; state MUL for WIDTH cycles, then DONE; done WIDTH+1 cycles after accept; {result_hi,result_lo} = full 2*WIDTH product.
REQ-017 DIVU: unsigned restoring, one quotient bit per cycle; same latency as MULTU; result_lo = quotient, result_hi = remainder.
REQ-018 DIVU by zero: result_lo = all ones, result_hi = alu_src1, div_by_zero=1, single-cycle latency.
REQ-019 SLT: signed compare; result_lo = 1 if src1 < src2 else 0.
REQ-020 ADD/SUB: WIDTH-bit wrap-around; ovf=1 on signed overflow, else 0.
REQ-021 For every non-MULTU/DIVU op result_hi SHALL be 0; undefined codes give all results 0, all flags 0.
REQ-022 ovf and div_by_zero SHALL be 0 for ops other than ADD/SUB and DIVU respectively.
REQ-023 busy = 1 exactly in MUL and DIV; done = 1 exactly in DONE.
REQ-024 DONE -> IDLE without start; DONE with start accepts the new op (back-to-back).
REQ-025 All outputs registered; results and flags held stable from done until next accepted start's completion.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE and clear busy, done, result_lo, result_hi, ovf, div_by_zero to 0, zero_bit to 1.
REQ-027 Reset mid-MULTU/DIVU SHALL abort the op; no done pulse SHALL follow.
REQ-028 Start coincident with rst_n=0 SHALL be ignored.

Configuration
REQ-029 Macro SEQ_ALU_DIV_EN: defined -> DIVU per REQ-017/018; undefined -> no divider logic, 1001 treated as undefined code (REQ-021), DIV state absent, div_by_zero tied 0.

Structure
REQ-030 Shared package alu_pkg SHALL hold the alu_ctr opcode constants and the FSM state enum.
REQ-031 Iterative engine SHALL be one sub-module seq_alu_muldiv (shared accumulator/shift register, mode select, bit counter); top holds FSM, single-cycle datapath, output registers.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+0x00000001 -> done next cycle, result_lo 0x80000000, ovf 1, zero_bit 0.
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done 33 cycles after accept, result_hi 0xFFFFFFFE, result_lo 0x00000001.
REQ-034 DIVU 100/7 -> done after 33 cycles, result_lo 14, result_hi 2; DIVU 0x1234/0 -> done next cycle, result_lo 0xFFFFFFFF, result_hi 0x1234, div_by_zero 1.
REQ-035 SLT 0xFFFFFFFF vs 0x00000001 -> result_lo 1; SUB 5-5 -> result_lo 0, zero_bit 1.
REQ-036 start pulsed during MULTU cycle 10 -> ignored, original product delivered; back-to-back ADD asserted in DONE cycle -> done again next cycle.
REQ-037 rst_n low during MULTU cycle 10 -> all outputs cleared, no done; following AND 0xF0F0 & 0xFF00 -> result_lo 0xF000.
